// File: rtl/arith_pkg.sv
// arith_pkg: definitions shared by the board ALU arithmetic blocks.
//   DEFAULT_WIDTH   default operand width of the divider
//   LED_ALL_ON/OFF  LEDR patterns for the error and normal cases
//   div_state_e     divider FSM states. FIXUP exists only when
//                   RESTORING_DIVIDER_SIGNED_EN is defined.
package arith_pkg;

  localparam int         DEFAULT_WIDTH = 4;
  localparam logic [9:0] LED_ALL_ON    = 10'h3FF;
  localparam logic [9:0] LED_ALL_OFF   = 10'h000;

`ifdef RESTORING_DIVIDER_SIGNED_EN
  typedef enum logic [1:0] {IDLE, RUN, DONE, FIXUP} div_state_e;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_e;
`endif

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
//   p_in   partial remainder before the step (always < y)
//   y      divisor
//   bit_in next dividend bit, MSB first
//   p_out  partial remainder after the step
//   q_bit  quotient bit produced by this step
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] p_in,
  input  logic [WIDTH-1:0] y,
  input  logic             bit_in,
  output logic [WIDTH-1:0] p_out,
  output logic             q_bit
);

  // Before the shift P < Y holds, so the shifted value fits in WIDTH+1
  // bits. The stored remainder therefore needs only WIDTH bits.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    shifted = {p_in, bit_in};
    trial   = shifted - {1'b0, y};
    // A clear top bit means the trial difference did not go negative.
    q_bit   = ~trial[WIDTH];
    p_out   = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/restoring_divider.sv
// restoring_divider: sequential restoring divider for the board ALU.
// It produces one quotient bit per clock behind a start/busy/done handshake.
//   CLOCK_50  clock, rising edge
//   reset     synchronous active-high reset
//   X, Y      dividend / divisor, sampled when a start is accepted
//   start     level-sampled request; ignored while a division is in flight
//   busy      high while iterating
//   done      one-cycle pulse when out/LEDR become valid
//   out       {remainder, quotient}, held until the next result
//   LEDR      all ones on divide-by-zero (or signed overflow), else zeros
// Optional: define RESTORING_DIVIDER_SIGNED_EN for two's-complement operands.
// That build adds one FIXUP cycle that restores the result signs.
module restoring_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH  // must be >= 2
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic [WIDTH-1:0]   X,
  input  logic [WIDTH-1:0]   Y,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out,
  output logic [9:0]         LEDR
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_e         state_q, state_d;
  // dvd_q shifts dividend bits out at the MSB and quotient bits in at the
  // LSB. After WIDTH steps it holds the quotient.
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [WIDTH-1:0]   p_q, p_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] out_q, out_d;
  logic [9:0]         ledr_q, ledr_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
`ifdef RESTORING_DIVIDER_SIGNED_EN
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH-1:0]   x_mag, y_mag;
`endif

  logic [WIDTH-1:0]   step_p;
  logic               step_q;
  logic [WIDTH-1:0]   dvd_next;

  div_step #(.WIDTH(WIDTH)) u_step (
    .p_in  (p_q),
    .y     (y_q),
    .bit_in(dvd_q[WIDTH-1]),
    .p_out (step_p),
    .q_bit (step_q)
  );

  assign dvd_next = {dvd_q[WIDTH-2:0], step_q};

  always_comb begin
    // NOTE: every *_d gets a default first, so no path through the case
    // leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    dvd_d   = dvd_q;
    y_d     = y_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    ledr_d  = ledr_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
`ifdef RESTORING_DIVIDER_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    ovf_d   = ovf_q;
    x_mag   = X[WIDTH-1] ? WIDTH'(-X) : X;
    y_mag   = Y[WIDTH-1] ? WIDTH'(-Y) : Y;
`endif

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          ledr_d = LED_ALL_OFF;
          if (Y == '0) begin
            // Divide-by-zero finishes immediately with a fixed result.
            state_d = DONE;
            out_d   = {X, {WIDTH{1'b1}}};
            ledr_d  = LED_ALL_ON;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = RUN;
            p_d     = '0;
            cnt_d   = CW'(WIDTH - 1);
            busy_d  = 1'b1;
`ifdef RESTORING_DIVIDER_SIGNED_EN
            dvd_d   = x_mag;
            y_d     = y_mag;
            qneg_d  = X[WIDTH-1] ^ Y[WIDTH-1];
            rneg_d  = X[WIDTH-1];
            ovf_d   = (X == {1'b1, {(WIDTH-1){1'b0}}}) && (Y == {WIDTH{1'b1}});
`else
            dvd_d   = X;
            y_d     = Y;
`endif
          end
        end
      end

      RUN: begin
        p_d   = step_p;
        dvd_d = dvd_next;
        if (cnt_q == '0) begin
`ifdef RESTORING_DIVIDER_SIGNED_EN
          // Keep busy through the sign fix-up cycle.
          state_d = FIXUP;
`else
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          out_d   = {step_p, dvd_next};
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

`ifdef RESTORING_DIVIDER_SIGNED_EN
      FIXUP: begin
        // The quotient magnitude of MIN / -1 is 2^(WIDTH-1). Left
        // unnegated, it reads back as MIN, which is the overflow result.
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        out_d   = {rneg_q ? WIDTH'(-p_q) : p_q,
                   qneg_q ? WIDTH'(-dvd_q) : dvd_q};
        ledr_d  = ovf_q ? LED_ALL_ON : LED_ALL_OFF;
      end
`endif

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    // NOTE: state uses non-blocking assignments, so all flops update
    // together from values sampled before the edge.
    if (reset) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      y_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      ledr_q  <= LED_ALL_OFF;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef RESTORING_DIVIDER_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      y_q     <= y_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      ledr_q  <= ledr_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef RESTORING_DIVIDER_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;
  assign LEDR = ledr_q;

endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: self-checking bench for restoring_divider.
// It applies directed vectors from a table, multi-cycle corner sequences and
// random operations. An arithmetic reference model supplies the expected
// values. It follows RESTORING_DIVIDER_SIGNED_EN when that macro is defined.
module tb_restoring_divider;

  localparam int W       = 4;
  localparam int MAX_LAT = 20;

  logic             CLOCK_50 = 1'b0;
  logic             reset;
  logic [W-1:0]     X, Y;
  logic             start;
  logic             busy, done;
  logic [2*W-1:0]   out;
  logic [9:0]       LEDR;

  int n_pass  = 0;
  int n_total = 0;

  restoring_divider #(.WIDTH(W)) dut (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .X       (X),
    .Y       (Y),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .out     (out),
    .LEDR    (LEDR)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference model. Latency counts clock edges from the edge that accepts
  // start up to and including the edge after which done is visible.
  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [2*W-1:0] o, output logic [9:0] led,
                                output int lat);
    if (y == 0) begin
      o   = {x, {W{1'b1}}};
      led = 10'h3FF;
      lat = 1;
    end else begin
`ifdef RESTORING_DIVIDER_SIGNED_EN
      int sx, sy, q, r;
      sx = $signed(x);
      sy = $signed(y);
      lat = W + 2;
      if (sx == -(1 << (W - 1)) && sy == -1) begin
        o   = {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};
        led = 10'h3FF;
      end else begin
        q   = sx / sy;  // truncates toward zero; remainder takes sign of x
        r   = sx % sy;
        o   = {r[W-1:0], q[W-1:0]};
        led = 10'h000;
      end
`else
      int q, r;
      q   = int'(x) / int'(y);
      r   = int'(x) % int'(y);
      o   = {r[W-1:0], q[W-1:0]};
      led = 10'h000;
      lat = W + 1;
`endif
    end
  endfunction

  // Issue one start and wait, bounded, for done. Operands are scrambled after
  // the accepting edge so that a design still reading X/Y would be caught.
  task automatic do_div(input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [2*W-1:0] o, output logic [9:0] led,
                        output int lat, output int bcnt);
    X = x; Y = y; start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    X = W'($urandom);
    Y = W'($urandom);
    lat = 1;
    bcnt = 0;
    while (done !== 1'b1 && lat < MAX_LAT) begin
      if (busy === 1'b1) bcnt++;
      @(posedge CLOCK_50); #1;
      lat++;
    end
    if (done !== 1'b1) lat = -1;
    o = out;
    led = LEDR;
  endtask

  typedef struct {
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [2*W-1:0] exp_out;
    logic [9:0]     exp_led;
    int             exp_lat;
  } vec_t;

  initial begin
    vec_t           vecs[$];
    logic [2*W-1:0] o, exp_o, held;
    logic [9:0]     led, exp_led;
    int             lat, exp_lat, bcnt;
    bit             seen;

    reset = 1'b1; start = 1'b0; X = '0; Y = '0;

    // Reset state
    repeat (2) @(posedge CLOCK_50);
    #1 reset = 1'b0;
    @(posedge CLOCK_50); #1;
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_out",  32'(out),  32'h00);
    check("reset_ledr", 32'(LEDR), 32'h000);

    // Directed table. Entries run back to back: each start lands in the
    // done cycle of the previous operation.
`ifdef RESTORING_DIVIDER_SIGNED_EN
    vecs.push_back('{4'h9, 4'd2, {4'hF, 4'hD}, 10'h000, 6});   // -7 / 2
    vecs.push_back('{4'h8, 4'hF, {4'h0, 4'h8}, 10'h3FF, 6});   // -8 / -1
    vecs.push_back('{4'd7, 4'd0, {4'd7, 4'hF}, 10'h3FF, 1});   // div by 0
    vecs.push_back('{4'd7, 4'hE, {4'd1, 4'hD}, 10'h000, 6});   // 7 / -2
    vecs.push_back('{4'hA, 4'hD, {4'd0, 4'd2}, 10'h000, 6});   // -6 / -3
    vecs.push_back('{4'd5, 4'd3, {4'd2, 4'd1}, 10'h000, 6});
`else
    vecs.push_back('{4'd13, 4'd3,  {4'd1, 4'd4},  10'h000, 5});
    vecs.push_back('{4'd7,  4'd0,  {4'd7, 4'hF},  10'h3FF, 1});
    vecs.push_back('{4'd15, 4'd1,  {4'd0, 4'd15}, 10'h000, 5});
    vecs.push_back('{4'd0,  4'd5,  {4'd0, 4'd0},  10'h000, 5});
    vecs.push_back('{4'd15, 4'd15, {4'd0, 4'd1},  10'h000, 5});
    vecs.push_back('{4'd1,  4'd15, {4'd1, 4'd0},  10'h000, 5});
    vecs.push_back('{4'd15, 4'd2,  {4'd1, 4'd7},  10'h000, 5});
    vecs.push_back('{4'd8,  4'd3,  {4'd2, 4'd2},  10'h000, 5});
`endif
    foreach (vecs[i]) begin
      do_div(vecs[i].x, vecs[i].y, o, led, lat, bcnt);
      check($sformatf("tbl%0d_out", i),  32'(o),   32'(vecs[i].exp_out));
      check($sformatf("tbl%0d_ledr", i), 32'(led), 32'(vecs[i].exp_led));
      check($sformatf("tbl%0d_lat", i),  32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("tbl%0d_busy", i), 32'(bcnt),
            32'((vecs[i].exp_lat == 1) ? 0 : vecs[i].exp_lat - 1));
    end

    // done lasts one cycle; out and LEDR hold while DONE idles.
    held = out;
    exp_led = LEDR;
    @(posedge CLOCK_50); #1;
    check("pulse_done", 32'(done), 32'h0);
    check("pulse_out",  32'(out),  32'(held));
    check("pulse_ledr", 32'(LEDR), 32'(exp_led));
    check("pulse_busy", 32'(busy), 32'h0);

    // A start raised while busy, with new operands, must be ignored.
    model(4'd9, 4'd2, exp_o, exp_led, exp_lat);
    X = 4'd9; Y = 4'd2; start = 1'b1;
    @(posedge CLOCK_50); #1;
    X = 4'd1; Y = 4'd1;
    @(posedge CLOCK_50); #1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    lat = 3;
    while (done !== 1'b1 && lat < MAX_LAT) begin
      @(posedge CLOCK_50); #1;
      lat++;
    end
    check("ign_lat",  32'(lat),  32'(exp_lat));
    check("ign_out",  32'(out),  32'(exp_o));
    check("ign_ledr", 32'(LEDR), 32'(exp_led));

    // Reset during RUN aborts the division: no done pulse, and out is cleared.
    X = 4'd14; Y = 4'd5; start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    @(posedge CLOCK_50); #1;
    check("abort_busy_pre", 32'(busy), 32'h1);
    reset = 1'b1;
    @(posedge CLOCK_50); #1;
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_out",  32'(out),  32'h00);
    check("abort_done", 32'(done), 32'h0);
    seen = 1'b0;
    repeat (10) begin
      @(posedge CLOCK_50); #1;
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    check("abort_quiet", 32'(seen), 32'h0);

    // Random operations against the reference model, with random idle gaps.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] rx, ry;
      rx = W'($urandom);
      ry = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      repeat ($urandom_range(0, 2)) @(posedge CLOCK_50);
      #1;
      model(rx, ry, exp_o, exp_led, exp_lat);
      do_div(rx, ry, o, led, lat, bcnt);
      check($sformatf("rnd%0d_out x=%0h y=%0h", i, rx, ry), 32'(o), 32'(exp_o));
      check($sformatf("rnd%0d_ledr", i), 32'(led), 32'(exp_led));
      check($sformatf("rnd%0d_lat", i),  32'(lat), 32'(exp_lat));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
